// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch and
// data load/store, with a per-transaction timeout and registered handshakes.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_owner, w_owner_next;
  logic              r_last_owner, w_last_owner_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_if_gnt, w_if_gnt_next;
  logic              r_if_ack, w_if_ack_next;
  logic              r_if_err, w_if_err_next;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
  logic              r_d_gnt, w_d_gnt_next;
  logic              r_d_ack, w_d_ack_next;
  logic              r_d_err, w_d_err_next;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic              r_busy, w_busy_next;
  logic              w_pick_data;
  logic              w_timeout;

  // On a tie the requester that did not own the bus last time wins.
  assign w_pick_data = d_req & (~if_req | (r_last_owner == OWN_FETCH));
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_FETCH;
      r_last_owner <= OWN_DATA;
      r_cnt        <= '0;
      r_if_gnt     <= 1'b0;
      r_if_ack     <= 1'b0;
      r_if_err     <= 1'b0;
      r_if_rdata   <= '0;
      r_d_gnt      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_cnt        <= w_cnt_next;
      r_if_gnt     <= w_if_gnt_next;
      r_if_ack     <= w_if_ack_next;
      r_if_err     <= w_if_err_next;
      r_if_rdata   <= w_if_rdata_next;
      r_d_gnt      <= w_d_gnt_next;
      r_d_ack      <= w_d_ack_next;
      r_d_err      <= w_d_err_next;
      r_d_rdata    <= w_d_rdata_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_busy       <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_cnt_next        = r_cnt;
    w_if_gnt_next     = 1'b0;
    w_if_ack_next     = 1'b0;
    w_if_err_next     = 1'b0;
    w_if_rdata_next   = r_if_rdata;
    w_d_gnt_next      = 1'b0;
    w_d_ack_next      = 1'b0;
    w_d_err_next      = 1'b0;
    w_d_rdata_next    = r_d_rdata;
    w_mem_req_next    = r_mem_req;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_busy_next       = r_busy;

    case (r_state)
      S_IDLE: begin
        if (if_req || d_req) begin
          w_owner_next      = w_pick_data;
          w_last_owner_next = w_pick_data;
          w_cnt_next        = '0;
          w_mem_req_next    = 1'b1;
          w_busy_next       = 1'b1;
          w_state_next      = S_BUSY;
          if (w_pick_data) begin
            w_d_gnt_next     = 1'b1;
            w_mem_we_next    = d_we;
            w_mem_addr_next  = d_addr;
            w_mem_wdata_next = d_wdata;
          end else begin
            w_if_gnt_next    = 1'b1;
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = if_addr;
            w_mem_wdata_next = '0;
          end
        end
      end

      S_BUSY: begin
        // mem_ack takes priority over a timeout landing in the same cycle.
        if (mem_ack || w_timeout) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_RESP;
          if (r_owner == OWN_DATA) begin
            w_d_ack_next = 1'b1;
            w_d_err_next = ~mem_ack;
            if (mem_ack && !r_mem_we) begin
              w_d_rdata_next = mem_rdata;
            end
          end else begin
            w_if_ack_next = 1'b1;
            w_if_err_next = ~mem_ack;
            if (mem_ack) begin
              w_if_rdata_next = mem_rdata;
            end
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_mem_req_next = 1'b0;
        w_busy_next    = 1'b0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  assign if_gnt    = r_if_gnt;
  assign if_ack    = r_if_ack;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port of the simple RISC-V core between instruction fetch and data load/store. Both requesters use a req/ack handshake. The block arbitrates round-robin, latches the winning request, and drives the memory bus until the memory acknowledges or a timeout expires. It then returns read data, and an error flag on timeout, to the owner. It sits between the core pipeline and the memory interface pins in the top-level TinyTapeout wrapper.

## Interface
Parameters:
- ADDR_W, 8, address width for both requesters and the memory port.
- DATA_W, 8, data width.
- TIMEOUT, 16, maximum BUSY cycles without mem_ack before abort. 0 disables the timeout. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse when fetch wins arbitration.
- if_ack  out  1  one-cycle pulse when the fetch transaction completes.
- if_err  out  1  valid with if_ack; 1 = timed out.
- if_rdata  out  DATA_W  fetch read data; updated only on if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt, d_ack, d_err  out  1  same semantics as the fetch equivalents.
- d_rdata  out  DATA_W  data read data; updated only on a d_ack for a read.
- mem_req  out  1  memory request; high throughout BUSY.
- mem_we  out  1  latched write enable; always 0 for fetch.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; sampled only in BUSY.
- busy  out  1  high in BUSY and RESP.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset goes to IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester that is not last_owner wins.
  - On a win: latch addr, we and wdata into the mem_* registers; set owner and last_owner; pulse the owner's gnt; clear the timeout counter; go to BUSY.
- last_owner resets to DATA, so the first tie goes to fetch.
- BUSY:
  - mem_ack=1: capture mem_rdata into the owner's rdata (skipped for data writes). Set the owner's ack=1 and err=0. Go to RESP.
  - Otherwise, counter == TIMEOUT-1 with TIMEOUT≠0: set the owner's ack=1 and err=1, leave that rdata unchanged, go to RESP.
  - Otherwise: increment the counter.
- RESP:
  - Lasts one cycle. Requests are ignored; mem_req=0. Go to IDLE.
  - The requester must drop its req in this cycle unless it wants a new transaction.
- Requests are never pre-empted. A req arriving during BUSY or RESP waits.
- mem_ack outside BUSY is ignored.
- mem_ack and timeout in the same cycle: mem_ack wins, err=0.
- Changes on the requester inputs after gnt have no effect; the latched values are used.

## Timing
- All outputs are registered. Reset values: all outputs 0, rdata 0, counter 0, state IDLE.
- rst asserted mid-transaction: at the next edge mem_req=0, no ack is issued, state is IDLE, and last_owner returns to DATA.
- Request sampled in IDLE at cycle T:
  - gnt=1, mem_req=1 and the mem_* bus are valid at T+1.
  - mem_ack seen at cycle A gives ack=1 and rdata valid at A+1, with mem_req=0.
  - IDLE at A+2. The earliest next gnt is at A+3.
- Zero-wait memory (mem_ack at T+1): ack at T+2. Throughput is one transaction per 3 cycles.
- Timeout: ack with err=1 at T+TIMEOUT+1.
- gnt and ack are each exactly one cycle wide, once per transaction.

## Test plan
- Reset: hold rst for 2 cycles -> all outputs 0, busy=0. Assert rst during BUSY -> mem_req=0 next cycle and no ack.
- Single fetch: if_addr=0x10, memory acks 2 cycles after mem_req with mem_rdata=0xA5 -> mem_addr=0x10 and mem_we=0. if_ack pulses once with if_rdata=0xA5 and if_err=0.
- Data write: d_we=1, d_addr=0x80, d_wdata=0x3C -> mem_we=1 and mem_wdata=0x3C. d_ack is returned and d_rdata is unchanged.
- Contention: if_req and d_req held continuously for 4 transactions -> grant order fetch, data, fetch, data. Each transaction's acks precede the next gnt.
- Timeout: TIMEOUT=16 and memory never acks -> ack with err=1 exactly 17 cycles after the request sample; the next request proceeds normally. Same test with mem_ack on the 16th BUSY cycle -> err=0.
- Stale ack: mem_ack pulsed during IDLE and during RESP -> no ack output and no change to rdata.
